// File: rtl/noise_channel_ctrl.sv
// Noisy-channel sequencer: per frame, XORs LFSR-derived 2-bit noise into the
// encoded symbol stream and counts the injected bit errors (optionally capped).
module noise_channel_ctrl #(
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 8,
    parameter int MAX_ERR   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       err_level,
    input  logic [7:0]       seed,
    input  logic [1:0]       in_sym,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       out_sym,
    output logic [1:0]       out_noise,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] bit_err_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [7:0]       lfsr_reg;
    logic [7:0]       err_level_reg;
    logic [CNT_W-1:0] sym_cnt_reg;
    logic [CNT_W-1:0] bit_err_cnt_reg;
    logic [1:0]       out_sym_reg;
    logic [1:0]       out_noise_reg;
    logic             out_valid_reg;

    logic             start_take;
    logic             accept;
    logic             last_sym;
    logic [1:0]       raw_noise;
    logic [1:0]       noise;
    logic [1:0]       raw_pop;
    logic [1:0]       noise_pop;
    logic [CNT_W:0]   err_sum;
    logic             cap_hit;
    logic [7:0]       lfsr_step;

    assign start_take = (state_reg == IDLE) && start;
    assign in_ready   = (state_reg == RUN) && (sym_cnt_reg < CNT_W'(FRAME_LEN))
                        && (!out_valid_reg || out_ready);
    assign accept     = in_valid && in_ready;
    assign last_sym   = (sym_cnt_reg == CNT_W'(FRAME_LEN - 1));

    // Noise decision: threshold compare, then all-or-nothing cap on the frame's error budget.
    assign raw_noise  = (lfsr_reg < err_level_reg) ? lfsr_reg[1:0] : 2'b00;
    assign raw_pop    = {1'b0, raw_noise[1]} + {1'b0, raw_noise[0]};
    assign err_sum    = {1'b0, bit_err_cnt_reg} + (CNT_W+1)'(raw_pop);
    assign cap_hit    = (MAX_ERR != 0) && (err_sum > (CNT_W+1)'(MAX_ERR));
    assign noise      = cap_hit ? 2'b00 : raw_noise;
    assign noise_pop  = {1'b0, noise[1]} + {1'b0, noise[0]};
    assign lfsr_step  = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && last_sym) state_next = DRAIN;
            DRAIN:   if (!out_valid_reg || out_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            lfsr_reg        <= 8'h01;
            err_level_reg   <= 8'h00;
            sym_cnt_reg     <= '0;
            bit_err_cnt_reg <= '0;
            out_sym_reg     <= 2'b00;
            out_noise_reg   <= 2'b00;
            out_valid_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_take) begin
                err_level_reg   <= err_level;
                lfsr_reg        <= (seed == 8'h00) ? 8'h01 : seed;
                sym_cnt_reg     <= '0;
                bit_err_cnt_reg <= '0;
            end else if (accept) begin
                lfsr_reg        <= lfsr_step;
                sym_cnt_reg     <= sym_cnt_reg + 1'b1;
                bit_err_cnt_reg <= bit_err_cnt_reg + CNT_W'(noise_pop);
            end
            // A new accept overwrites the output register even when it is being drained.
            if (accept) begin
                out_sym_reg   <= in_sym ^ noise;
                out_noise_reg <= noise;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_sym     = out_sym_reg;
    assign out_noise   = out_noise_reg;
    assign out_valid   = out_valid_reg;
    assign busy        = (state_reg == RUN) || (state_reg == DRAIN);
    assign frame_done  = (state_reg == DONE);
    assign bit_err_cnt = bit_err_cnt_reg;

endmodule
